// File: rtl/lane_traffic_engine.sv
// lane_traffic_engine
//   N-lane traffic engine. On each enabled frame tick it runs one pass:
//   UPDATE (one cycle) moves every lane's car by STEP_PX pixels when that lane's
//   frame divider expires. The car moves in the lane's direction and wraps at
//   SCREEN_W. SCAN then tests the player box against one lane per cycle.
//   DONE pulses o_scan_done. A hit latches a sticky collision flag and records
//   the first lane that hit. Ticks that arrive while a pass is in flight are
//   remembered, one deep.
// Ports
//   CLK, RST_N        clock, asynchronous active-low reset
//   i_frame_tick      one-cycle pulse per video frame
//   i_enable          1 = traffic runs, 0 = positions and dividers frozen
//   i_restart         synchronous return to reset state (highest priority)
//   i_level           difficulty, shortens every lane's step period
//   i_lane_dir        bit k: 0 = lane k moves +x, 1 = lane k moves -x
//   i_player_x/_y     player box left/top edge
//   o_car_x           lane k car left edge at [k*X_W +: X_W]
//   o_busy            high during UPDATE and SCAN
//   o_scan_done       one-cycle pulse in DONE
//   o_collision       sticky hit flag
//   o_collision_lane  lane index of the first hit
module lane_traffic_engine #(
   parameter int N_LANES  = 4,
   parameter int X_W      = 10,
   parameter int Y_W      = 10,
   parameter int SCREEN_W = 640,
   parameter int CAR_W    = 32,
   parameter int PLAYER_W = 32,
   parameter int LANE_Y0  = 96,
   parameter int LANE_H   = 32,
   parameter int STEP_PX  = 4,
   parameter int BASE_DIV = 4,
   parameter int LVL_W    = 3
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   i_frame_tick,
   input  logic                   i_enable,
   input  logic                   i_restart,
   input  logic [LVL_W-1:0]       i_level,
   input  logic [N_LANES-1:0]     i_lane_dir,
   input  logic [X_W-1:0]         i_player_x,
   input  logic [Y_W-1:0]         i_player_y,
   output logic [N_LANES*X_W-1:0] o_car_x,
   output logic                   o_busy,
   output logic                   o_scan_done,
   output logic                   o_collision,
   output logic [2:0]             o_collision_lane
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UPDATE = 2'd1,
      ST_SCAN   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // The divider must hold the longest period (odd lanes, level 0).
   localparam int DIV_W = $clog2(BASE_DIV + 2);
   localparam int CW    = ((DIV_W > LVL_W) ? DIV_W : LVL_W) + 1;

   localparam logic [X_W:0]     SCREEN_E  = (X_W+1)'(SCREEN_W);
   localparam logic [X_W:0]     STEP_E    = (X_W+1)'(STEP_PX);
   localparam logic [X_W:0]     CAR_E     = (X_W+1)'(CAR_W);
   localparam logic [X_W:0]     PLAYER_E  = (X_W+1)'(PLAYER_W);
   localparam logic [CW-1:0]    ONE_C     = CW'(32'd1);
   localparam logic [DIV_W-1:0] ONE_D     = DIV_W'(32'd1);
   localparam logic [2:0]       LAST_LANE = 3'(N_LANES - 32'sd1);
   localparam logic [2:0]       LANE_ONE  = 3'd1;

   state_t         state_r;
   state_t         state_nxt_s;
   logic           go_s;
   logic           upd_en_s;
   logic           hit_sel_s;
   logic           busy_nxt_s;
   logic           done_nxt_s;
   logic           pending_r;
   logic           busy_r;
   logic           scan_done_r;
   logic           collision_r;
   logic [2:0]     lane_r;
   logic [2:0]     collision_lane_r;
   logic [7:0]     hit_all_s;
   logic [CW-1:0]  lvl_e_s;
   logic [X_W:0]   px_e_s;
   logic [Y_W:0]   py_e_s;

   assign go_s     = (i_frame_tick & i_enable) | pending_r;
   assign upd_en_s = (state_r == ST_UPDATE) & i_enable;
   assign lvl_e_s  = CW'(i_level);
   assign px_e_s   = {1'b0, i_player_x};
   assign py_e_s   = {1'b0, i_player_y};
   // hit_all_s is padded to 8 lanes so the 3-bit scan index always selects a defined bit.
   assign hit_sel_s = hit_all_s[lane_r];

   for (genvar k = 0; k < N_LANES; k++) begin : g_lane
      localparam logic [X_W-1:0] X_RST  = X_W'((k * SCREEN_W / N_LANES) % SCREEN_W);
      localparam logic [CW-1:0]  BASE_K = CW'(BASE_DIV + (k % 32'sd2));
      localparam logic [Y_W:0]   TOP_K  = (Y_W+1)'(LANE_Y0 + k * LANE_H);
      localparam logic [Y_W:0]   BOT_K  = (Y_W+1)'(LANE_Y0 + (k + 32'sd1) * LANE_H);

      logic [X_W-1:0]   x_r;
      logic [DIV_W-1:0] div_r;
      logic [CW-1:0]    period_s;
      logic             step_s;
      logic [X_W:0]     xe_s;
      logic [X_W:0]     right_s;
      logic [X_W:0]     left_s;
      logic [X_W-1:0]   x_nxt_s;
      logic             unused_msb_s;

      assign period_s = (BASE_K > lvl_e_s) ? (BASE_K - lvl_e_s) : ONE_C;
      // A level raised between passes can leave div_r past the new period.
      // Using >= steps the car at once instead of counting through a wrap.
      assign step_s   = (CW'(div_r) + ONE_C) >= period_s;
      assign xe_s     = {1'b0, x_r};
      assign right_s  = ((xe_s + STEP_E) >= SCREEN_E) ? (xe_s + STEP_E - SCREEN_E)
                                                     : (xe_s + STEP_E);
      assign left_s   = (xe_s < STEP_E) ? (xe_s + SCREEN_E - STEP_E) : (xe_s - STEP_E);
      // The wrapped result is always below SCREEN_W, so the top bit is always zero.
      assign {unused_msb_s, x_nxt_s} = i_lane_dir[k] ? left_s : right_s;
      assign o_car_x[k*X_W +: X_W] = x_r;
      // Only the unwrapped car span [x, x+CAR_W) is tested, even when it overhangs SCREEN_W.
      assign hit_all_s[k] = (py_e_s >= TOP_K) && (py_e_s < BOT_K)
                            && (px_e_s < xe_s + CAR_E) && (xe_s < px_e_s + PLAYER_E);

      // Lane position and frame divider; only an enabled UPDATE cycle moves them
      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            x_r   <= X_RST;
            div_r <= {DIV_W{1'b0}};
         end else if (i_restart) begin
            x_r   <= X_RST;
            div_r <= {DIV_W{1'b0}};
         end else if (upd_en_s) begin
            div_r <= step_s ? {DIV_W{1'b0}} : (div_r + ONE_D);
            x_r   <= step_s ? x_nxt_s : x_r;
         end else begin
            x_r   <= x_r;
            div_r <= div_r;
         end
      end
   end

   for (genvar u = N_LANES; u < 8; u++) begin : g_pad
      assign hit_all_s[u] = 1'b0;
   end

   // FSM state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r <= ST_IDLE;
      end else if (i_restart) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state: one UPDATE, one SCAN cycle per lane, one DONE
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (go_s) state_nxt_s = ST_UPDATE;
            else      state_nxt_s = ST_IDLE;
         end
         ST_UPDATE: state_nxt_s = ST_SCAN;
         ST_SCAN: begin
            if (lane_r == LAST_LANE) state_nxt_s = ST_DONE;
            else                     state_nxt_s = ST_SCAN;
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM outputs are decoded from the next state, so the registered flags match the state
   always_comb begin
      busy_nxt_s = 1'b0;
      done_nxt_s = 1'b0;
      case (state_nxt_s)
         ST_UPDATE: busy_nxt_s = 1'b1;
         ST_SCAN:   busy_nxt_s = 1'b1;
         ST_DONE:   done_nxt_s = 1'b1;
         default: begin
            busy_nxt_s = 1'b0;
            done_nxt_s = 1'b0;
         end
      endcase
   end

   // Scan index, pending tick, sticky collision and registered status flags
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pending_r        <= 1'b0;
         lane_r           <= 3'd0;
         busy_r           <= 1'b0;
         scan_done_r      <= 1'b0;
         collision_r      <= 1'b0;
         collision_lane_r <= 3'd0;
      end else if (i_restart) begin
         pending_r        <= 1'b0;
         lane_r           <= 3'd0;
         busy_r           <= 1'b0;
         scan_done_r      <= 1'b0;
         collision_r      <= 1'b0;
         collision_lane_r <= 3'd0;
      end else begin
         busy_r      <= busy_nxt_s;
         scan_done_r <= done_nxt_s;
         // IDLE always consumes the pending request (go_s already includes it).
         if (state_r == ST_IDLE)             pending_r <= 1'b0;
         else if (i_frame_tick && i_enable)  pending_r <= 1'b1;
         else                                pending_r <= pending_r;
         if (state_r == ST_SCAN) lane_r <= lane_r + LANE_ONE;
         else                    lane_r <= 3'd0;
         if ((state_r == ST_SCAN) && hit_sel_s && !collision_r) begin
            collision_r      <= 1'b1;
            collision_lane_r <= lane_r;
         end else begin
            collision_r      <= collision_r;
            collision_lane_r <= collision_lane_r;
         end
      end
   end

   assign o_busy           = busy_r;
   assign o_scan_done      = scan_done_r;
   assign o_collision      = collision_r;
   assign o_collision_lane = collision_lane_r;

endmodule

// File: tb/tb_lane_traffic_engine.sv
// tb_lane_traffic_engine
//   Directed scenarios plus randomized ticks, directions, player boxes,
//   enables and restarts for lane_traffic_engine. Every cycle is checked
//   against a behavioural frame-pass model. The model tracks how many cycles
//   into a pass the engine is, rather than copying any state encoding.
module tb_lane_traffic_engine;

   localparam int N  = 4;
   localparam int XW = 10;
   localparam int SW = 640;
   localparam int STEP = 4;
   localparam int CARW = 32;
   localparam int PLW  = 32;
   localparam int LY0  = 96;
   localparam int LH   = 32;
   localparam int BDIV = 4;

   logic            CLK = 1'b0;
   logic            RST_N;
   logic            i_frame_tick;
   logic            i_enable;
   logic            i_restart;
   logic [2:0]      i_level;
   logic [N-1:0]    i_lane_dir;
   logic [XW-1:0]   i_player_x;
   logic [9:0]      i_player_y;
   logic [N*XW-1:0] o_car_x;
   logic            o_busy;
   logic            o_scan_done;
   logic            o_collision;
   logic [2:0]      o_collision_lane;

   always #5 CLK = ~CLK;

   lane_traffic_engine dut (
      .CLK              (CLK),
      .RST_N            (RST_N),
      .i_frame_tick     (i_frame_tick),
      .i_enable         (i_enable),
      .i_restart        (i_restart),
      .i_level          (i_level),
      .i_lane_dir       (i_lane_dir),
      .i_player_x       (i_player_x),
      .i_player_y       (i_player_y),
      .o_car_x          (o_car_x),
      .o_busy           (o_busy),
      .o_scan_done      (o_scan_done),
      .o_collision      (o_collision),
      .o_collision_lane (o_collision_lane)
   );

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;

   // Model: car positions, frames since last step, cycles into the current
   // pass (-1 = idle; 0 = update; 1..N = lane scans; N+1 = done pulse).
   int m_x   [N];
   int m_cnt [N];
   int m_ph;
   int m_pend;
   int m_coll;
   int m_clane;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < N; k++) begin
         m_x[k]   = k * SW / N;
         m_cnt[k] = 0;
      end
      m_ph    = -1;
      m_pend  = 0;
      m_coll  = 0;
      m_clane = 0;
   endfunction

   // Apply one clock edge to the model using the inputs currently driven.
   function automatic void model_step();
      int per;
      int lane;
      int top;
      int px;
      int py;
      int nxt;
      if (i_restart) begin
         model_reset();
      end else if (m_ph < 0) begin
         if ((i_frame_tick && i_enable) || m_pend != 0) begin
            m_ph   = 0;
            m_pend = 0;
         end
      end else begin
         if (i_frame_tick && i_enable) m_pend = 1;
         if (m_ph == 0) begin
            if (i_enable) begin
               for (int k = 0; k < N; k++) begin
                  per = BDIV + (k % 2) - int'(i_level);
                  if (per < 1) per = 1;
                  m_cnt[k] = m_cnt[k] + 1;
                  if (m_cnt[k] >= per) begin
                     m_cnt[k] = 0;
                     if (i_lane_dir[k]) m_x[k] = (m_x[k] + SW - STEP) % SW;
                     else               m_x[k] = (m_x[k] + STEP) % SW;
                  end
               end
            end
         end else if (m_ph <= N) begin
            lane = m_ph - 1;
            top  = LY0 + lane * LH;
            px   = int'(i_player_x);
            py   = int'(i_player_y);
            if (m_coll == 0 && py >= top && py < top + LH
                && px < m_x[lane] + CARW && m_x[lane] < px + PLW) begin
               m_coll  = 1;
               m_clane = lane;
            end
         end
         nxt = (m_ph == N + 1) ? -1 : m_ph + 1;
         m_ph = nxt;
      end
   endfunction

   task automatic compare_all();
      logic [N*XW-1:0] ex;
      for (int k = 0; k < N; k++) ex[k*XW +: XW] = XW'(m_x[k]);
      check_eq("car_x", 64'(o_car_x), 64'(ex));
      check_eq("busy", 64'(o_busy), 64'(m_ph >= 0 && m_ph <= N));
      check_eq("scan_done", 64'(o_scan_done), 64'(m_ph == N + 1));
      check_eq("collision", 64'(o_collision), 64'(m_coll));
      check_eq("coll_lane", 64'(o_collision_lane), 64'(m_clane));
      if (o_scan_done === 1'b1) done_cnt++;
   endtask

   // Drive one cycle (called just after a falling edge), advance, compare.
   task automatic run_cycle(input logic tick);
      i_frame_tick = tick;
      model_step();
      @(negedge CLK);
      compare_all();
      i_frame_tick = 1'b0;
      i_restart    = 1'b0;
   endtask

   task automatic do_restart();
      i_restart = 1'b1;
      run_cycle(1'b0);
   endtask

   localparam logic [N*XW-1:0] RST_X = {10'd480, 10'd320, 10'd160, 10'd0};

   initial begin
      RST_N        = 1'b0;
      i_frame_tick = 1'b0;
      i_enable     = 1'b0;
      i_restart    = 1'b0;
      i_level      = 3'd0;
      i_lane_dir   = 4'b0000;
      i_player_x   = 10'd0;
      i_player_y   = 10'd0;
      model_reset();
      repeat (2) @(negedge CLK);
      check_eq("rst_car_x", 64'(o_car_x), 64'(RST_X));
      compare_all();
      RST_N    = 1'b1;
      i_enable = 1'b1;

      // Level 0, all lanes moving right, eight frame passes.
      for (int t = 0; t < 8; t++) begin
         run_cycle(1'b1);
         repeat (9) run_cycle(1'b0);
      end
      check_eq("lvl0_lane0", 64'(o_car_x[9:0]), 64'd8);
      check_eq("lvl0_lane1", 64'(o_car_x[19:10]), 64'd164);

      // Wrap left from 0 and back right from 636 at period 1.
      i_level    = 3'd7;
      i_lane_dir = 4'b0001;
      do_restart();
      run_cycle(1'b1);
      repeat (8) run_cycle(1'b0);
      check_eq("wrap_left", 64'(o_car_x[9:0]), 64'd636);
      i_lane_dir = 4'b0000;
      run_cycle(1'b1);
      repeat (8) run_cycle(1'b0);
      check_eq("wrap_right", 64'(o_car_x[9:0]), 64'd0);

      // Player overlapping lane 0 car, then just clear of it.
      i_level    = 3'd0;
      i_player_x = 10'd10;
      i_player_y = 10'd100;
      do_restart();
      run_cycle(1'b1);
      repeat (5) run_cycle(1'b0);
      check_eq("hit_done", 64'(o_scan_done), 64'd1);
      check_eq("hit_flag", 64'(o_collision), 64'd1);
      check_eq("hit_lane", 64'(o_collision_lane), 64'd0);
      i_player_x = 10'd42;
      do_restart();
      run_cycle(1'b1);
      repeat (5) run_cycle(1'b0);
      check_eq("miss_done", 64'(o_scan_done), 64'd1);
      check_eq("miss_flag", 64'(o_collision), 64'd0);

      // Tick during scan is queued; a third tick in the same pass is dropped.
      do_restart();
      done_cnt = 0;
      run_cycle(1'b1);
      run_cycle(1'b0);
      run_cycle(1'b1);
      run_cycle(1'b0);
      run_cycle(1'b1);
      repeat (25) run_cycle(1'b0);
      check_eq("pending_passes", 64'(done_cnt), 64'd2);

      // Asynchronous reset mid-scan with the collision flag already set.
      i_player_x = 10'd10;
      do_restart();
      run_cycle(1'b1);
      run_cycle(1'b0);
      run_cycle(1'b0);
      #2 RST_N = 1'b0;
      #1;
      model_reset();
      check_eq("arst_car_x", 64'(o_car_x), 64'(RST_X));
      check_eq("arst_busy", 64'(o_busy), 64'd0);
      check_eq("arst_coll", 64'(o_collision), 64'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      compare_all();

      // Synchronous restart mid-scan.
      run_cycle(1'b1);
      run_cycle(1'b0);
      run_cycle(1'b0);
      do_restart();
      check_eq("srst_busy", 64'(o_busy), 64'd0);
      check_eq("srst_car_x", 64'(o_car_x), 64'(RST_X));

      // Randomized traffic; the level only changes together with a restart.
      for (int t = 0; t < 3000; t++) begin
         if (t % 64 == 0) i_enable = ($urandom_range(0, 9) != 0);
         i_lane_dir = N'($urandom);
         i_player_x = 10'($urandom_range(0, 639));
         i_player_y = 10'($urandom_range(64, 255));
         if ($urandom_range(0, 149) == 0) begin
            i_restart = 1'b1;
            i_level   = 3'($urandom_range(0, 7));
         end
         run_cycle($urandom_range(0, 4) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
